// File: rtl/hyperbus_fixture.sv
// rtl/hyperbus_fixture.sv - HyperBus memory fixture: register block, burst FSM with latency splits, byte-lane backing memory.
module hyperbus_fixture #(
   parameter int NumChips = 2,
   parameter int NumPhys  = 2,
   parameter int MemWords = 8192
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                reg_valid_i,
   input  logic                reg_write_i,
   input  logic [3:0]          reg_addr_i,
   input  logic [31:0]         reg_wdata_i,
   output logic [31:0]         reg_rdata_o,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_write_i,
   input  logic [31:0]         req_addr_i,
   input  logic [11:0]         req_len_i,
   input  logic [2:0]          req_size_i,
   input  logic                w_valid_i,
   output logic                w_ready_o,
   input  logic [127:0]        w_data_i,
   input  logic [15:0]         w_strb_i,
   input  logic                w_last_i,
   output logic                r_valid_o,
   input  logic                r_ready_i,
   output logic [127:0]        r_data_o,
   output logic                r_last_o,
   output logic                r_err_o,
   output logic                b_valid_o,
   input  logic                b_ready_i,
   output logic                b_err_o,
   output logic [NumChips-1:0] cs_o,
   output logic                busy_o
);

   localparam int          AddrW     = (MemWords > 1) ? $clog2(MemWords) : 1;
   localparam logic [31:0] MemBytes  = 32'(MemWords * 16);
   localparam logic [31:0] ChipBytes = 32'(MemWords * 16 / NumChips);

   typedef enum logic [2:0] {
      StIdle,
      StLat,
      StWdata,
      StRdata,
      StResp
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       latency_q, latency_d;
   logic             enable_q, enable_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [31:0]      addr_q, addr_d;
   logic [11:0]      len_q, len_d;
   logic [11:0]      beat_q, beat_d;
   logic [2:0]       size_q, size_d;
   logic             write_q, write_d;
   logic [8:0]       sub_q, sub_d;
   logic [3:0]       lat_cnt_q, lat_cnt_d;
   logic             berr_q, berr_d;

   logic [127:0]     mem [MemWords];

   logic [31:0]      step;
   logic [31:0]      aligned;
   logic [31:0]      next_addr;
   logic [3:0]       lane_lo;
   logic [3:0]       lane_hi;
   logic [15:0]      lane_mask;
   logic [AddrW-1:0] word_idx;
   logic [8:0]       sub_inc;
   logic             beat_err;
   logic             last_beat;
   logic             split;
   logic             data_phase;
   logic             wr_fire;
   logic             adv;
   logic             unused_wdata;

   assign unused_wdata = ^reg_wdata_i[31:4];

   // Register file; read data is registered so it appears the cycle after the strobe.
   always_comb begin
      latency_d = latency_q;
      enable_d  = enable_q;
      rdata_d   = rdata_q;
      if (reg_valid_i) begin
         if (reg_write_i) begin
            if (reg_addr_i == 4'h0) latency_d = reg_wdata_i[3:0];
            if (reg_addr_i == 4'h4) enable_d = reg_wdata_i[0];
         end
         case (reg_addr_i)
            4'h0:    rdata_d = {28'd0, latency_q};
            4'h4:    rdata_d = {31'd0, enable_q};
            4'h8:    rdata_d = 32'(NumPhys);
            default: rdata_d = 32'd0;
         endcase
      end
   end

   // Beat geometry: lanes run from the beat address up to the end of its size-aligned window.
   always_comb begin
      step      = 32'd1 << size_q;
      aligned   = addr_q & ~(step - 32'd1);
      next_addr = aligned + step;
      lane_lo   = addr_q[3:0];
      lane_hi   = aligned[3:0] + step[3:0] - 4'd1;
      for (int i = 0; i < 16; i++) begin
         lane_mask[i] = (4'(i) >= lane_lo) && (4'(i) <= lane_hi);
      end
      word_idx   = addr_q[4 +: AddrW];
      beat_err   = (size_q > 3'd4) || (addr_q >= MemBytes);
      last_beat  = (beat_q == len_q);
      sub_inc    = sub_q + 9'd1;
      split      = (sub_inc == 9'd256) || (next_addr[31:12] != addr_q[31:12]);
      data_phase = (state_q == StWdata) || (state_q == StRdata);
      wr_fire    = (state_q == StWdata) && w_valid_i && !rst_i;
   end

   always_comb begin
      cs_o = '0;
      for (int c = 0; c < NumChips; c++) begin
         cs_o[c] = data_phase && (addr_q >= 32'(c) * ChipBytes) &&
                   (addr_q < 32'(c + 1) * ChipBytes);
      end
   end

   assign r_data_o    = ((state_q == StRdata) && !beat_err) ? mem[word_idx] : '0;
   assign r_last_o    = (state_q == StRdata) && last_beat;
   assign r_err_o     = (state_q == StRdata) && beat_err;
   assign b_err_o     = (state_q == StResp) && berr_q;
   assign busy_o      = (state_q != StIdle);
   assign reg_rdata_o = rdata_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      size_d      = size_q;
      write_d     = write_q;
      beat_d      = beat_q;
      sub_d       = sub_q;
      lat_cnt_d   = lat_cnt_q;
      berr_d      = berr_q;
      req_ready_o = 1'b0;
      w_ready_o   = 1'b0;
      r_valid_o   = 1'b0;
      b_valid_o   = 1'b0;
      adv         = 1'b0;
      case (state_q)
         StIdle: begin
            req_ready_o = enable_q;
            if (req_valid_i && enable_q) begin
               addr_d    = req_addr_i;
               len_d     = req_len_i;
               size_d    = req_size_i;
               write_d   = req_write_i;
               beat_d    = '0;
               sub_d     = '0;
               berr_d    = 1'b0;
               lat_cnt_d = latency_q;
               if (latency_q == 4'd0) state_d = req_write_i ? StWdata : StRdata;
               else                   state_d = StLat;
            end
         end
         StLat: begin
            if (lat_cnt_q <= 4'd1) state_d = write_q ? StWdata : StRdata;
            else                   lat_cnt_d = lat_cnt_q - 4'd1;
         end
         StWdata: begin
            w_ready_o = 1'b1;
            if (w_valid_i) begin
               berr_d = berr_q | beat_err | (w_last_i != last_beat);
               if (last_beat) state_d = StResp;
               else           adv = 1'b1;
            end
         end
         StRdata: begin
            r_valid_o = 1'b1;
            if (r_ready_i) begin
               if (last_beat) state_d = StIdle;
               else           adv = 1'b1;
            end
         end
         StResp: begin
            b_valid_o = 1'b1;
            if (b_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // A new sub-burst starts after 256 beats or on a 4 KiB page change and pays latency again.
      if (adv) begin
         beat_d = beat_q + 12'd1;
         addr_d = next_addr;
         sub_d  = split ? 9'd0 : sub_inc;
         if (split) begin
            lat_cnt_d = latency_q;
            if (latency_q != 4'd0) state_d = StLat;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         latency_q <= 4'd6;
         enable_q  <= 1'b0;
         rdata_q   <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         write_q   <= 1'b0;
         beat_q    <= '0;
         sub_q     <= '0;
         lat_cnt_q <= '0;
         berr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         latency_q <= latency_d;
         enable_q  <= enable_d;
         rdata_q   <= rdata_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         write_q   <= write_d;
         beat_q    <= beat_d;
         sub_q     <= sub_d;
         lat_cnt_q <= lat_cnt_d;
         berr_q    <= berr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_fire && !beat_err) begin
         for (int i = 0; i < 16; i++) begin
            if (lane_mask[i] && w_strb_i[i]) mem[word_idx][8*i +: 8] <= w_data_i[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_hyperbus_fixture.sv
// tb/tb_hyperbus_fixture.sv - randomized self-checking bench for hyperbus_fixture against a byte-level memory model.
module tb_hyperbus_fixture;

   localparam int MemBytes  = 8192 * 16;
   localparam int ChipBytes = MemBytes / 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         reg_valid, reg_write;
   logic [3:0]   reg_addr;
   logic [31:0]  reg_wdata, reg_rdata;
   logic         req_valid, req_ready, req_write;
   logic [31:0]  req_addr;
   logic [11:0]  req_len;
   logic [2:0]   req_size;
   logic         w_valid, w_ready, w_last;
   logic [127:0] w_data;
   logic [15:0]  w_strb;
   logic         r_valid, r_ready, r_last, r_err;
   logic [127:0] r_data;
   logic         b_valid, b_ready, b_err;
   logic [1:0]   cs;
   logic         busy;

   always #5 clk = ~clk;

   hyperbus_fixture dut (
      .clk_i(clk), .rst_i(rst),
      .reg_valid_i(reg_valid), .reg_write_i(reg_write), .reg_addr_i(reg_addr),
      .reg_wdata_i(reg_wdata), .reg_rdata_o(reg_rdata),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_len_i(req_len), .req_size_i(req_size),
      .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
      .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data), .r_last_o(r_last), .r_err_o(r_err),
      .b_valid_o(b_valid), .b_ready_i(b_ready), .b_err_o(b_err),
      .cs_o(cs), .busy_o(busy)
   );

   int         n_checks = 0;
   int         n_pass   = 0;
   int         cur_lat  = 6;
   logic [7:0] ref_mem   [MemBytes];
   bit         ref_known [MemBytes];

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic longint beat_addr(longint base, int size, int k);
      longint step = longint'(1) << size;
      if (k == 0) return base;
      return (base & ~(step - 1)) + longint'(k) * step;
   endfunction

   function automatic bit beat_bad(longint a, int size);
      return (size > 4) || (a >= longint'(MemBytes));
   endfunction

   function automatic logic [1:0] exp_cs(longint a);
      if (a >= longint'(MemBytes)) return 2'b00;
      return (a < longint'(ChipBytes)) ? 2'b01 : 2'b10;
   endfunction

   function automatic void model_write(longint a, int size, logic [127:0] d, logic [15:0] s);
      longint step = longint'(1) << size;
      int     lo   = int'(a % 16);
      int     hi   = int'(((a & ~(step - 1)) + step - 1) % 16);
      int     base = int'(a & ~longint'(15));
      if (beat_bad(a, size)) return;
      for (int i = lo; i <= hi; i++) begin
         if (s[i]) begin
            ref_mem[base + i]   = d[8*i +: 8];
            ref_known[base + i] = 1'b1;
         end
      end
   endfunction

   task automatic model_read(input longint a, input int size, output logic [127:0] d, output logic [127:0] m);
      int base = int'(a & ~longint'(15));
      d = '0;
      m = '1;
      if (beat_bad(a, size)) return;
      for (int i = 0; i < 16; i++) begin
         d[8*i +: 8] = ref_mem[base + i];
         m[8*i +: 8] = ref_known[base + i] ? 8'hff : 8'h00;
      end
   endtask

   function automatic int exp_lat(longint addr, int len, int size, int lat);
      int splits = 0;
      int last   = 0;
      for (int k = 1; k <= len; k++) begin
         if ((k - last == 256) ||
             ((beat_addr(addr, size, k) >> 12) != (beat_addr(addr, size, k - 1) >> 12))) begin
            splits++;
            last = k;
         end
      end
      return lat * (splits + 1);
   endfunction

   task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
      reg_valid = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = d;
      @(posedge clk); #1;
      reg_valid = 1'b0; reg_write = 1'b0;
   endtask

   task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
      reg_valid = 1'b1; reg_write = 1'b0; reg_addr = a;
      @(posedge clk); #1;
      reg_valid = 1'b0;
      @(negedge clk);
      d = reg_rdata;
      @(posedge clk); #1;
   endtask

   task automatic issue_req(input bit wr, input longint addr, input int len, input int size);
      int cyc = 0;
      bit ok  = 1'b0;
      req_valid = 1'b1; req_write = wr; req_addr = 32'(addr);
      req_len = 12'(len); req_size = 3'(size);
      while (!ok && cyc < 50) begin
         @(negedge clk);
         if (req_ready) ok = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      req_valid = 1'b0;
      if (!ok) check_eq("req_timeout", 0, 1);
   endtask

   task automatic do_write(input longint addr, input int len, input int size,
                           input logic [15:0] strb_fix, input bit strb_rand,
                           input logic [127:0] data_fix, input bit data_rand,
                           input bit flip_last, input int stall_pct);
      int     k = 0, cyc = 0, lat_cyc = 0;
      int     limit = (len + 1) * 8 + 200;
      bit     exp_err = flip_last;
      bit     done = 1'b0;
      longint a;
      issue_req(1'b1, addr, len, size);
      while (k <= len && cyc < limit) begin
         w_valid = ($urandom_range(99) >= stall_pct);
         w_data  = data_rand ? {$urandom, $urandom, $urandom, $urandom} : data_fix;
         w_strb  = strb_rand ? 16'($urandom) : strb_fix;
         w_last  = ((k == len) != flip_last);
         @(negedge clk);
         if (busy && !w_ready) lat_cyc++;
         if (w_valid && w_ready) begin
            a = beat_addr(addr, size, k);
            check_eq("wr_cs", cs, exp_cs(a));
            if (beat_bad(a, size)) exp_err = 1'b1;
            model_write(a, size, w_data, w_strb);
            k++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      w_valid = 1'b0;
      if (k <= len) check_eq("wr_beat_timeout", k, len + 1);
      check_eq("wr_lat_cycles", lat_cyc, exp_lat(addr, len, size, cur_lat));
      cyc = 0;
      while (!done && cyc < 100) begin
         b_ready = 1'($urandom_range(1));
         @(negedge clk);
         if (b_valid && b_ready) begin
            check_eq("b_err", b_err, exp_err);
            done = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      b_ready = 1'b0;
      if (!done) check_eq("b_timeout", 0, 1);
      @(negedge clk);
      check_eq("wr_idle_after", busy, 0);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input longint addr, input int len, input int size, input int stall_pct);
      int           k = 0, cyc = 0, lat_cyc = 0;
      int           limit = (len + 1) * 8 + 200;
      longint       a;
      logic [127:0] d, m;
      issue_req(1'b0, addr, len, size);
      while (k <= len && cyc < limit) begin
         r_ready = ($urandom_range(99) >= stall_pct);
         @(negedge clk);
         if (busy && !r_valid) lat_cyc++;
         if (r_valid && r_ready) begin
            a = beat_addr(addr, size, k);
            model_read(a, size, d, m);
            check_eq($sformatf("rd_data@%0h", a), r_data & m, d & m);
            check_eq("rd_last", r_last, (k == len));
            check_eq("rd_err", r_err, beat_bad(a, size));
            check_eq("rd_cs", cs, exp_cs(a));
            k++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      r_ready = 1'b0;
      if (k <= len) check_eq("rd_beat_timeout", k, len + 1);
      check_eq("rd_lat_cycles", lat_cyc, exp_lat(addr, len, size, cur_lat));
      @(negedge clk);
      check_eq("rd_idle_after", busy, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] v;
      longint      ra;
      int          rl, rs, k;

      rst = 1'b1; reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0; req_size = '0;
      w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; r_ready = 1'b0; b_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_valids", {w_ready, r_valid, b_valid}, 0);
      check_eq("rst_cs", cs, 0);
      @(posedge clk); #1;

      reg_rd(4'h0, v); check_eq("reg_latency_rst", v, 6);
      reg_rd(4'h4, v); check_eq("reg_enable_rst", v, 0);
      reg_rd(4'h8, v); check_eq("reg_numphys", v, 2);
      reg_rd(4'hc, v); check_eq("reg_unmapped", v, 0);
      reg_wr(4'h8, 32'h5);
      reg_rd(4'h8, v); check_eq("reg_numphys_ro", v, 2);

      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h100; req_len = '0; req_size = 3'd4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("disabled_ready", req_ready, 0);
         check_eq("disabled_busy", busy, 0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      reg_wr(4'h4, 32'h1);
      reg_rd(4'h4, v); check_eq("reg_enable_set", v, 1);

      do_write(32'h100, 0, 4, 16'hffff, 1'b0, 128'hbad0beefcafedeadb00b88887777aa55, 1'b0, 1'b0, 20);
      do_read(32'h100, 0, 4, 20);

      for (int i = 0; i < 16; i++) do_write(32'h30 + i, 0, 0, 16'(1) << i, 1'b0, '0, 1'b1, 1'b0, 0);
      do_read(32'h3e, 0, 1, 0);

      do_write(32'h900, 0, 4, 16'hffff, 1'b0, '0, 1'b1, 1'b0, 0);
      do_write(32'h902, 2, 2, 16'hf0ff, 1'b0, '0, 1'b1, 1'b0, 10);
      do_read(32'h900, 2, 2, 10);
      do_read(32'h900, 0, 4, 0);

      reg_wr(4'h0, 32'h2); cur_lat = 2;
      do_write(32'ha00, 4089, 4, 16'hffff, 1'b0, '0, 1'b1, 1'b0, 0);
      reg_wr(4'h0, 32'h1); cur_lat = 1;
      do_read(32'ha00, 4089, 4, 10);

      do_write(32'h100, 0, 5, 16'hffff, 1'b0, '0, 1'b1, 1'b0, 0);
      do_read(32'h100, 0, 4, 0);
      do_write(32'h20000, 0, 4, 16'hffff, 1'b0, '0, 1'b1, 1'b0, 0);
      do_read(32'h20000, 0, 4, 0);
      do_read(32'h100, 0, 5, 0);
      do_write(32'h1fff0, 2, 4, 16'hffff, 1'b0, '0, 1'b1, 1'b0, 0);
      do_read(32'h1fff0, 2, 4, 0);

      do_write(32'h200, 3, 4, 16'hffff, 1'b0, '0, 1'b1, 1'b1, 10);
      do_read(32'h200, 3, 4, 0);

      reg_wr(4'h0, 32'h0); cur_lat = 0;
      do_write(32'h0ff0, 3, 4, 16'hffff, 1'b0, '0, 1'b1, 1'b0, 0);
      do_read(32'h0ff0, 3, 4, 0);

      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(3) == 0) begin
            cur_lat = $urandom_range(3);
            reg_wr(4'h0, 32'(cur_lat));
         end
         rs = ($urandom_range(9) == 0) ? 5 : $urandom_range(4);
         rl = $urandom_range(40);
         ra = ($urandom_range(7) == 0) ? longint'(MemBytes - $urandom_range(1, 256))
                                       : longint'($urandom_range(MemBytes - 1));
         do_write(ra, rl, rs, '0, 1'b1, '0, 1'b1, 1'b0, 15);
         do_read(ra, rl, rs, 15);
      end

      reg_wr(4'h0, 32'h2); cur_lat = 2;
      issue_req(1'b1, 32'h4000, 20, 4);
      k = 0;
      for (int i = 0; i < 8; i++) begin
         w_valid = 1'b1; w_data = {$urandom, $urandom, $urandom, $urandom};
         w_strb = 16'hffff; w_last = 1'b0;
         @(negedge clk);
         if (w_valid && w_ready) begin
            model_write(beat_addr(32'h4000, 4, k), 4, w_data, w_strb);
            k++;
         end
         @(posedge clk); #1;
      end
      w_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_valids", {req_ready, w_ready, r_valid, b_valid}, 0);
      check_eq("midrst_cs_err", {cs, r_err, b_err}, 0);
      @(posedge clk); #1;
      cur_lat = 6;
      reg_rd(4'h0, v); check_eq("midrst_latency", v, 6);
      reg_rd(4'h4, v); check_eq("midrst_enable", v, 0);
      reg_wr(4'h4, 32'h1);
      do_read(32'h4000, 20, 4, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hyperbus_fixture.md
HYPERBUS_FIXTURE -- requirements
Module: hyperbus_fixture

Interface
REQ-001 SHALL have parameter NumChips, default 2, number of chip selects; memory split evenly across chips.
REQ-002 SHALL have parameter NumPhys, default 2, PHY count; reported in register 0x8, no functional effect.
REQ-003 SHALL have parameter MemWords, default 8192, count of 128-bit backing words (128 KiB).
REQ-004 clk_i  in  1  sole clock, all logic on rising edge.
REQ-005 rst_i  in  1  reset, synchronous and active-high.
REQ-006 reg_valid_i/reg_write_i  in  1/1  register access strobe, write select.
REQ-007 reg_addr_i  in  4  byte address; reg_wdata_i in 32; reg_rdata_o out 32 (valid cycle after strobe).
REQ-008 req_valid_i/req_ready_o  in/out  1/1  command handshake.
REQ-009 req_write_i in 1; req_addr_i in 32; req_len_i in 12 (beats-1); req_size_i in 3 (log2 bytes/beat).
REQ-010 w_valid_i/w_ready_o in/out 1/1; w_data_i in 128; w_strb_i in 16; w_last_i in 1.
REQ-011 r_valid_o/r_ready_i out/in 1/1; r_data_o out 128; r_last_o out 1; r_err_o out 1.
REQ-012 b_valid_o/b_ready_i out/in 1/1; b_err_o out 1.
REQ-013 cs_o  out  NumChips  one-hot active chip during data phase; busy_o out 1.

Function
REQ-014 Registers: 0x0 latency (4 bits, reset 6), 0x4 enable (bit0, reset 0), 0x8 read-only NumPhys; others read 0, writes ignored.
REQ-015 req_ready_o SHALL be 1 only in IDLE with enable=1.
REQ-016 FSM states: IDLE, LAT, WDATA, RDATA, RESP.
REQ-017 IDLE->LAT on command handshake; capture addr, len, size, write.
REQ-018 LAT SHALL last exactly latency register value cycles (0 => skip), then ->WDATA or RDATA.
REQ-019 Beat address: beat0 = req_addr; beat k = (req_addr aligned down to 2^size) + k*2^size.
REQ-020 Active lanes per beat: bytes [addr mod 16, aligned_end mod 16]; beat0 unaligned covers addr..aligned boundary-1.
REQ-021 Write: byte written iff lane active AND w_strb bit set; w_ready_o=1 in WDATA; one beat per w handshake.
REQ-022 Read: r_data_o SHALL carry full stored 128-bit word of beat address; r_last_o on beat req_len.
REQ-023 Sub-burst split: after every 256 beats SHALL re-enter LAT before continuing (latency penalty per split), transparent to beat stream.
REQ-024 Address crossing a 4 KiB boundary SHALL also re-enter LAT.
REQ-025 cs_o = one-hot of addr / (MemWords*16/NumChips) during WDATA/RDATA, else 0.
REQ-026 Error: size>4 or any beat address >= MemWords*16 => beat error; writes dropped, reads return 0, r_err_o set for that beat.
REQ-027 WDATA->RESP after beat req_len; b_err_o = OR of write beat errors; b_valid_o held until b_ready_i.
REQ-028 w_last_i mismatch with beat count SHALL set b_err_o; beat count governs termination.
REQ-029 RDATA->IDLE after last handshake; r_valid_o held until r_ready_i.
REQ-030 busy_o=1 whenever state != IDLE.
REQ-031 Register writes during a transaction SHALL apply; latency change takes effect at next LAT entry.

Reset
REQ-032 rst_i SHALL force IDLE, registers to defaults, all valid/ready/cs/err outputs 0, mid-transaction included; memory contents not cleared.

Verification
REQ-033 Write reg 0x4=1; 128-bit write addr 0x100 len 0 size 4 data 0xbad0beefcafedeadb00b88887777aa55 strb 0xffff; read back -> identical data, r_last=1, no errors.
REQ-034 Byte writes 0x30..0x3f, strb one-hot matching lane, distinct bytes; 16-bit read 0x3e -> bytes 14/15 as written.
REQ-035 Unaligned 32-bit write addr 0x902 len 2 strb 0xF0FF: beat0 writes only bytes 2-3; reads return consistent data.
REQ-036 Write addr 0xa00 len 4089 size 4: LAT entered at every 256 beats/4 KiB crossing, total 4090 beats, b_err=0; read matches.
REQ-037 size=5 or addr 0x20000 -> b_err/r_err=1, memory unchanged.
REQ-038 Enable=0 -> req_ready_o=0; rst_i mid-burst -> IDLE next cycle, outputs 0.
